// File: rtl/shiftreg_pkg.sv
// Shared definitions for the serial link: transmitter FSM states and the
// bit-order encoding that both link ends agree on.
package shiftreg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_serializer_if.sv
// Load handshake and serial output bundle of the parallel-to-serial transmitter.
interface shift_serializer_if #(
  parameter int SIZE = 8
);

  logic [SIZE-1:0] data;
  logic            load_valid;
  logic            load_ready;
  logic            dir;
  logic            en;
  logic            q;
  logic            q_valid;
  logic            busy;
  logic            done;

  modport master (
    output data, load_valid, dir, en,
    input  load_ready, q, q_valid, busy, done
  );

  modport slave (
    input  data, load_valid, dir, en,
    output load_ready, q, q_valid, busy, done
  );

endinterface

// File: rtl/shift_serializer.sv
// Parallel-in/serial-out transmitter: loads a word on valid/ready, then emits
// one bit per consumer strobe in the bit order captured at load time.
module shift_serializer
  import shiftreg_pkg::*;
#(
  parameter int SIZE = 8
) (
  input logic               clk,
  input logic               rst,
  shift_serializer_if.slave bus
);

  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(SIZE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  state_t          state_r;
  state_t          state_s;
  logic [SIZE-1:0] sh_r;
  logic [SIZE-1:0] sh_s;
  logic            order_r;
  logic            order_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;

  // State, shifter, order and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      sh_r    <= {SIZE{1'b0}};
      order_r <= DIR_MSB_FIRST;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      sh_r    <= sh_s;
      order_r <= order_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; the word, order and remaining-bit count only change on a
  // load or on a consumer strobe while shifting.
  always_comb begin
    state_s = state_r;
    sh_s    = sh_r;
    order_s = order_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.load_valid) begin
          sh_s    = bus.data;
          order_s = bus.dir;
          cnt_s   = CNT_FULL;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (bus.en && (cnt_r == CNT_ONE)) begin
          sh_s    = {SIZE{1'b0}};
          cnt_s   = CNT_ZERO;
          state_s = DONE;
        end else if (bus.en) begin
          cnt_s = cnt_r - CNT_ONE;
          if (order_r == DIR_LSB_FIRST) begin
            sh_s = {1'b0, sh_r[SIZE-1:1]};
          end else begin
            sh_s = {sh_r[SIZE-2:0], 1'b0};
          end
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        sh_s    = {SIZE{1'b0}};
        order_s = DIR_MSB_FIRST;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  assign bus.load_ready = (state_r == IDLE);
  assign bus.q_valid    = (state_r == SHIFT);
  assign bus.busy       = (state_r != IDLE);
  assign bus.done       = (state_r == DONE);
  assign bus.q          = (state_r != SHIFT)          ? 1'b0 :
                          (order_r == DIR_MSB_FIRST)  ? sh_r[SIZE-1] : sh_r[0];

endmodule

// File: tb/tb_shift_serializer.sv
// Self-checking bench for shift_serializer: expected serial bits are queued at
// load time and popped as the transmitter presents them.
module tb_shift_serializer;

  localparam int SIZE = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  bit   sb[$];

  shift_serializer_if #(.SIZE(SIZE)) bus ();

  shift_serializer #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [SIZE-1:0] w, input logic d);
    for (int i = 0; i < SIZE; i++) begin
      if (d == 1'b0) sb.push_back(w[SIZE-1-i]);
      else           sb.push_back(w[i]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.load_valid = 1'b1; bus.en = 1'b1; bus.data = 8'hA5; bus.dir = 1'b0;
    tick();
    tick();
    rst = 1'b0; bus.load_valid = 1'b0; bus.en = 1'b0;
    total++;
    if ({bus.load_ready, bus.q, bus.q_valid, bus.busy, bus.done} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_outputs: got rdy,q,qv,busy,done=%b required 10000",
               {bus.load_ready, bus.q, bus.q_valid, bus.busy, bus.done});
    end
    tick();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_load: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_msb_first();
    bit exp;
    bus.data = 8'hC1; bus.dir = 1'b0; bus.load_valid = 1'b1;
    push_word(8'hC1, 1'b0);
    tick();
    bus.load_valid = 1'b0; bus.en = 1'b1;
    for (int c = 1; c <= SIZE; c++) begin
      exp = sb.pop_front();
      total++;
      if (bus.q_valid !== 1'b1 || bus.q !== exp) begin
        bad++;
        $display("FAIL msb_bit%0d: q=%b q_valid=%b required q=%b q_valid=1", c, bus.q, bus.q_valid, exp);
      end
      tick();
    end
    total++;
    if (bus.done !== 1'b1 || bus.q_valid !== 1'b0 || bus.load_ready !== 1'b0) begin
      bad++;
      $display("FAIL msb_done_cycle9: done=%b q_valid=%b load_ready=%b required 1,0,0",
               bus.done, bus.q_valid, bus.load_ready);
    end
    bus.en = 1'b0;
    tick();
    total++;
    if (bus.load_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL msb_idle_cycle10: load_ready=%b busy=%b done=%b required 1,0,0",
               bus.load_ready, bus.busy, bus.done);
    end
  endtask

  task automatic test_lsb_first();
    bit exp;
    bus.data = 8'hC1; bus.dir = 1'b1; bus.load_valid = 1'b1;
    push_word(8'hC1, 1'b1);
    tick();
    bus.load_valid = 1'b0; bus.en = 1'b1;
    for (int c = 1; c <= SIZE; c++) begin
      bus.dir  = ~bus.dir;
      bus.data = 8'($urandom);
      exp = sb.pop_front();
      total++;
      if (bus.q_valid !== 1'b1 || bus.q !== exp) begin
        bad++;
        $display("FAIL lsb_bit%0d: q=%b q_valid=%b required q=%b q_valid=1", c, bus.q, bus.q_valid, exp);
      end
      tick();
    end
    bus.en = 1'b0;
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("FAIL lsb_done: done=%b required 1", bus.done);
    end
    tick();
  endtask

  task automatic test_gapped();
    bit   pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int   strobes = 0;
    int   dones   = 0;
    bit   exp;
    bus.data = 8'h5A; bus.dir = 1'b0; bus.load_valid = 1'b1;
    push_word(8'h5A, 1'b0);
    tick();
    bus.load_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      bus.en = pat[k % 6];
      if (bus.done === 1'b1) begin
        dones++;
        total++;
        if (strobes != SIZE) begin
          bad++;
          $display("FAIL gap_done_timing: strobes=%0d at done required %0d", strobes, SIZE);
        end
      end
      if (bus.q_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL gap_extra_bit: q_valid=1 required 0 after %0d strobes", strobes);
        end else begin
          exp = bus.en ? sb.pop_front() : sb[0];
          total++;
          if (bus.q !== exp) begin
            bad++;
            $display("FAIL gap_bit: strobe=%0d en=%b q=%b required %b", strobes, bus.en, bus.q, exp);
          end
          if (bus.en) strobes++;
        end
      end
      tick();
    end
    bus.en = 1'b0;
    total++;
    if (dones != 1 || sb.size() != 0) begin
      bad++;
      $display("FAIL gap_frame_end: done_pulses=%0d left=%0d required 1 and 0", dones, sb.size());
    end
  endtask

  task automatic test_mid_reset();
    bit exp;
    int dones = 0;
    bus.data = 8'hFF; bus.dir = 1'b0; bus.load_valid = 1'b1;
    push_word(8'hFF, 1'b0);
    tick();
    bus.load_valid = 1'b0; bus.en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      exp = sb.pop_front();
      total++;
      if (bus.q !== exp) begin
        bad++;
        $display("FAIL abort_bit%0d: q=%b required %b", c, bus.q, exp);
      end
      tick();
    end
    rst = 1'b1; bus.en = 1'b0;
    tick();
    rst = 1'b0;
    sb.delete();
    total++;
    if ({bus.load_ready, bus.q, bus.q_valid, bus.busy, bus.done} !== 5'b10000) begin
      bad++;
      $display("FAIL abort_idle: rdy,q,qv,busy,done=%b required 10000",
               {bus.load_ready, bus.q, bus.q_valid, bus.busy, bus.done});
    end
    for (int c = 0; c < 3; c++) begin
      if (bus.done === 1'b1) dones++;
      tick();
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL abort_no_done: done pulses=%0d required 0", dones);
    end
    bus.data = 8'h01; bus.load_valid = 1'b1;
    push_word(8'h01, 1'b0);
    tick();
    bus.load_valid = 1'b0; bus.en = 1'b1;
    for (int c = 0; c < SIZE; c++) begin
      exp = sb.pop_front();
      total++;
      if (bus.q_valid !== 1'b1 || bus.q !== exp) begin
        bad++;
        $display("FAIL reload_bit%0d: q=%b q_valid=%b required %b", c, bus.q, bus.q_valid, exp);
      end
      tick();
    end
    bus.en = 1'b0;
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("FAIL reload_done: done=%b required 1", bus.done);
    end
    tick();
  endtask

  task automatic test_loopback();
    logic [SIZE-1:0] words[4] = '{8'h00, 8'hFF, 8'h96, 8'h3B};
    logic [SIZE-1:0] rx = '0;
    logic [SIZE-1:0] rx_next;
    logic [SIZE-1:0] exp_word = '0;
    int              idx    = 0;
    int              frames = 0;
    bit              exp;
    bus.dir = 1'b0; bus.data = words[0]; bus.load_valid = 1'b1;
    for (int c = 0; c < 400 && frames < 4; c++) begin
      bus.en = ($urandom_range(0, 3) != 0);
      if (bus.done === 1'b1) begin
        frames++;
        total++;
        if (rx !== exp_word) begin
          bad++;
          $display("FAIL loop_word%0d: receiver=%h required %h", frames, rx, exp_word);
        end
      end
      if (bus.q_valid === 1'b1 && bus.en && sb.size() > 0) begin
        exp = sb.pop_front();
        total++;
        if (bus.q !== exp) begin
          bad++;
          $display("FAIL loop_bit: frame=%0d q=%b required %b", idx, bus.q, exp);
        end
      end
      if (bus.load_ready === 1'b1 && bus.load_valid) begin
        total++;
        if (bus.busy !== 1'b0 || idx >= 4) begin
          bad++;
          $display("FAIL loop_load: busy=%b index=%0d required busy=0 index<4", bus.busy, idx);
        end
        push_word(words[idx % 4], 1'b0);
        exp_word = words[idx % 4];
        idx++;
      end
      rx_next = (bus.q_valid === 1'b1 && bus.en) ? {rx[SIZE-2:0], bus.q} : rx;
      tick();
      rx = rx_next;
      bus.load_valid = (idx < 4);
      bus.data       = (idx < 4) ? words[idx % 4] : 8'h00;
    end
    bus.en = 1'b0; bus.load_valid = 1'b0;
    total++;
    if (frames != 4 || idx != 4) begin
      bad++;
      $display("FAIL loop_frames: frames=%0d loads=%0d required 4 and 4 within budget", frames, idx);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    bus.data = '0; bus.load_valid = 1'b0; bus.dir = 1'b0; bus.en = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_gapped();
    test_mid_reset();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_serializer.md
Name: shift_serializer

Overview:
- Parallel-in/serial-out transmitter. It is the sending end of the serial link whose receiving end is the team's `shiftreg` (serial `d` in, `en` strobe, `dir` select).
- Accepts a SIZE-bit word through a valid/ready load handshake, then presents it one bit per consumer `en` strobe, in an order chosen per frame.
- Sits between the stack calculator datapath and any serial consumer, so stack words can be streamed out bit by bit.

Parameters:
- SIZE, 8, word width in bits; must be ≥ 2.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- data  input  SIZE  parallel word to transmit.
- load_valid  input  1  producer offers `data`.
- load_ready  output  1  block can accept a word (high only in IDLE).
- dir  input  1  bit order, sampled at load only. 0 = MSB first; 1 = LSB first.
- en  input  1  consumer strobe; the bit currently on `q` is consumed at this edge.
- q  output  1  current serial bit.
- q_valid  output  1  `q` holds a frame bit.
- busy  output  1  frame in progress (SHIFT or DONE).
- done  output  1  one-cycle pulse after the last bit is consumed.

Behaviour:
- State machine: IDLE, SHIFT, DONE. Internal regs: `sh` (SIZE bits), `order` (1 bit), `cnt` (width $clog2(SIZE+1)).
- Reset (rst high at posedge):
  - state=IDLE, sh=0, order=0, cnt=0.
  - Outputs after that edge: load_ready=1, q=0, q_valid=0, busy=0, done=0.
  - rst has priority over every other input, including mid-frame. An aborted frame produces no done pulse.
- Output decode (combinational from state and registers):
  - load_ready = (state==IDLE).
  - q_valid = (state==SHIFT).
  - busy = (state!=IDLE).
  - done = (state==DONE).
  - q = sh[SIZE-1] if order==0, else sh[0]; q=0 whenever state!=SHIFT.
- IDLE:
  - `en` is ignored.
  - On load_valid & load_ready: sh←data, order←dir, cnt←SIZE, go to SHIFT.
  - The first bit appears on q the cycle after the load edge.
- SHIFT:
  - load_valid is ignored (load_ready=0). Changes on `data` or `dir` have no effect.
  - en=0: hold all state.
  - en=1 and cnt>1: cnt←cnt-1. If order==0, sh←{sh[SIZE-2:0],1'b0}; if order==1, sh←{1'b0,sh[SIZE-1:1]}.
  - en=1 and cnt==1: go to DONE, sh←0, cnt←0.
  - Exactly SIZE en strobes per frame, with arbitrary gaps between them.
- DONE:
  - Lasts one cycle: done=1, load_ready=0, `en` ignored.
  - Unconditional transition to IDLE.
  - Back-to-back frames therefore have a 2-cycle minimum gap between the last-bit edge and the next load edge.
- Pairing rule: feed `q` to the receiver `d` and `en & q_valid` to the receiver `en`.
  - Transmitter dir=0 with receiver dir=0 reconstructs the word unchanged in the receiver `q` after SIZE strobes.

Decomposition:
- Package `shiftreg_pkg`:
  - state enum typedef (IDLE, SHIFT, DONE);
  - constants DIR_MSB_FIRST=1'b0 and DIR_LSB_FIRST=1'b1, shared with the receiver.
- No sub-module. Counter, shifter and FSM fit in one module.

Test Plan:
- Reset: assert rst 2 cycles with load_valid=1 and en=1 → no load occurs. After deassert: load_ready=1, q=0, q_valid=0, busy=0, done=0.
- MSB-first, 8'hC1, dir=0, en held high from the first SHIFT cycle:
  - q sequence 1,1,0,0,0,0,0,1 on 8 consecutive q_valid cycles;
  - done=1 on cycle 9; load_ready=1 on cycle 10.
- LSB-first, 8'hC1, dir=1:
  - q sequence 1,0,0,0,0,0,1,1;
  - toggling `dir` and `data` mid-frame leaves the sequence unchanged.
- Gapped strobes: 8'h5A, dir=0, en pattern 1,0,0,1,1,0 repeated → same 8 bits 0,1,0,1,1,0,1,0. q is stable during en=0 cycles. done fires once, after the 8th strobe.
- Reset mid-frame: load 8'hFF, give 3 strobes, assert rst → next cycle IDLE with q=0 and no done pulse. A new load of 8'h01 then streams 0,0,0,0,0,0,0,1.
- Loopback to `shiftreg` (SIZE=8, both dir=0): random words 8'h00, 8'hFF, 8'h96, 8'h3B → receiver `q` equals the sent word on the cycle done=1. load_valid held high continuously → one load per frame, never during busy.
